// File: rtl/shift_sequencer_pkg.sv
// Shared constants, opcode encodings and sequencer state encodings for the
// register-specified shift path.
package shift_sequencer_pkg;

    localparam int FULLW      = 32;
    localparam int WIDTH      = 5;
    localparam int SHIFTCODEW = 2;

    localparam logic [SHIFTCODEW-1:0] LSL = 2'd0;
    localparam logic [SHIFTCODEW-1:0] LSR = 2'd1;
    localparam logic [SHIFTCODEW-1:0] ASR = 2'd2;
    localparam logic [SHIFTCODEW-1:0] ROR = 2'd3;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_PASS1 = 2'd1,
        SEQ_PASS2 = 2'd2,
        SEQ_RESP  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/shift_sequencer_shifter32.sv
// Combinational 32-bit barrel shifter with a 5-bit amount; amount 0 encodes
// "by 32" for LSL/LSR/ASR and RRX for ROR.
module shifter32
    import shift_sequencer_pkg::*;
(
    input  logic [FULLW-1:0]      data,
    input  logic [WIDTH-1:0]      shiftby,
    input  logic [SHIFTCODEW-1:0] code,
    input  logic                  cin,
    output logic [FULLW-1:0]      out,
    output logic                  carryout
);

    logic        [WIDTH:0]       amt;
    logic        [2*FULLW-1:0]   wide;
    logic signed [2*FULLW-1:0]   swide;

    // Working in a double-width field leaves the last bit shifted out sitting
    // right next to the result, which is where the carry comes from.
    always_comb begin
        amt      = (shiftby == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, shiftby};
        wide     = '0;
        swide    = '0;
        out      = data;
        carryout = cin;
        case (code)
            LSL: begin
                wide     = {{FULLW{1'b0}}, data} << amt;
                out      = wide[FULLW-1:0];
                carryout = wide[FULLW];
            end
            LSR: begin
                wide     = {data, {FULLW{1'b0}}} >> amt;
                out      = wide[2*FULLW-1:FULLW];
                carryout = wide[FULLW-1];
            end
            ASR: begin
                swide    = $signed({data, {FULLW{1'b0}}}) >>> amt;
                out      = swide[2*FULLW-1:FULLW];
                carryout = swide[FULLW-1];
            end
            default: begin
                if (shiftby == '0) begin
                    out      = {cin, data[FULLW-1:1]};
                    carryout = data[0];
                end else begin
                    wide     = {data, data} >> shiftby;
                    out      = wide[FULLW-1:0];
                    carryout = wide[FULLW-1];
                end
            end
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Decomposes an ARM register-specified shift (amount 0..255) into 0, 1 or 2
// passes through a 5-bit-amount barrel shifter, behind valid/ready handshakes.
module shift_sequencer
    import shift_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [FULLW-1:0]      req_data,
    input  logic [7:0]            req_amount,
    input  logic [SHIFTCODEW-1:0] req_code,
    input  logic                  req_cflag,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [FULLW-1:0]      resp_data,
    output logic                  resp_carry
);

    seq_state_t state, state_nx;

    logic [FULLW-1:0]      op_data;
    logic [SHIFTCODEW-1:0] op_code;
    logic                  op_cflag;
    logic [WIDTH-1:0]      op_shiftby;
    logic                  op_two;
    logic [FULLW-1:0]      mid_data;

    logic                  cls_trivial;
    logic [FULLW-1:0]      cls_data;
    logic                  cls_carry;
    logic                  cls_two;
    logic [WIDTH-1:0]      cls_shiftby;
    logic [SHIFTCODEW-1:0] cls_code;

    logic [FULLW-1:0]      sh_data;
    logic [WIDTH-1:0]      sh_by;
    logic [SHIFTCODEW-1:0] sh_code;
    logic [FULLW-1:0]      sh_out;
    logic                  sh_carry;

    logic accept;

    assign req_ready  = (state == SEQ_IDLE);
    assign resp_valid = (state == SEQ_RESP);
    assign accept     = req_ready && req_valid;

    // Classify the incoming request; shiftby 0 is only ever chosen for
    // ASR/LSR "by 32", so the shifter never sees an RRX.
    always_comb begin
        cls_trivial = 1'b0;
        cls_data    = req_data;
        cls_carry   = req_cflag;
        cls_two     = 1'b0;
        cls_shiftby = req_amount[WIDTH-1:0];
        cls_code    = req_code;
        if (req_amount == 8'd0) begin
            cls_trivial = 1'b1;
        end else begin
            case (req_code)
                LSL, LSR: begin
                    if (req_amount > 8'd32) begin
                        cls_trivial = 1'b1;
                        cls_data    = '0;
                        cls_carry   = 1'b0;
                    end else if (req_amount == 8'd32) begin
                        if (req_code == LSL) begin
                            cls_two     = 1'b1;
                            cls_shiftby = WIDTH'(16);
                        end else begin
                            cls_shiftby = '0;
                        end
                    end
                end
                ASR: begin
                    if (req_amount >= 8'd32)
                        cls_shiftby = '0;
                end
                default: begin
                    if (req_amount[WIDTH-1:0] == '0) begin
                        cls_trivial = 1'b1;
                        cls_carry   = req_data[FULLW-1];
                    end
                end
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            SEQ_IDLE:  if (req_valid) state_nx = cls_trivial ? SEQ_RESP : SEQ_PASS1;
            SEQ_PASS1: state_nx = op_two ? SEQ_PASS2 : SEQ_RESP;
            SEQ_PASS2: state_nx = SEQ_RESP;
            SEQ_RESP:  if (resp_ready) state_nx = SEQ_IDLE;
            default:   state_nx = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= SEQ_IDLE;
        else
            state <= state_nx;
    end

    // The second LSL #32 pass recirculates the first-pass result.
    always_comb begin
        sh_data = op_data;
        sh_by   = op_shiftby;
        sh_code = op_code;
        if (state == SEQ_PASS2) begin
            sh_data = mid_data;
            sh_by   = WIDTH'(16);
            sh_code = LSL;
        end
    end

    shifter32 u_shifter (
        .data     (sh_data),
        .shiftby  (sh_by),
        .code     (sh_code),
        .cin      (op_cflag),
        .out      (sh_out),
        .carryout (sh_carry)
    );

    always_ff @(posedge clk) begin
        if (reset_n && accept) begin
            op_data    <= req_data;
            op_code    <= cls_code;
            op_cflag   <= req_cflag;
            op_shiftby <= cls_shiftby;
            op_two     <= cls_two;
        end
        if (reset_n && state == SEQ_PASS1 && op_two)
            mid_data <= sh_out;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            resp_data  <= '0;
            resp_carry <= 1'b0;
        end else if (accept && cls_trivial) begin
            resp_data  <= cls_data;
            resp_carry <= cls_carry;
        end else if ((state == SEQ_PASS1 && !op_two) || state == SEQ_PASS2) begin
            resp_data  <= sh_out;
            resp_carry <= sh_carry;
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: reset, shift vectors with latency,
// backpressure and reset during a pass.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_data;
    logic [7:0]  req_amount;
    logic [1:0]  req_code;
    logic        req_cflag;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_carry;

    int checks = 0;
    int errors = 0;

    shift_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_amount (req_amount),
        .req_code   (req_code),
        .req_cflag  (req_cflag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_carry (resp_carry)
    );

    always #5 clk = ~clk;

    // Issue one request and wait (bounded) for resp_valid; resp stays pending.
    task automatic run_req(input logic [31:0] d, input logic [7:0] a,
                           input logic [1:0] c, input logic cf,
                           output logic [31:0] od, output logic oc, output int lat);
        req_valid  = 1'b1;
        req_data   = d;
        req_amount = a;
        req_code   = c;
        req_cflag  = cf;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!resp_valid) lat = 99;
        od = resp_data;
        oc = resp_carry;
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b0 || resp_data !== 32'h0 || resp_carry !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: valid=%b data=%h carry=%b ready=%b want 0 0 0 1",
                     resp_valid, resp_data, resp_carry, req_ready);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
        logic [31:0] vd [12] = '{32'h0000_0001, 32'h8000_0001, 32'h8000_0001, 32'h8000_0000,
                                 32'h8000_0000, 32'h0000_0001, 32'h0000_0003, 32'h1234_5678,
                                 32'h8000_0000, 32'h0000_0018, 32'h0000_00F0, 32'hC000_0000};
        logic [7:0]  va [12] = '{8'd4, 8'd32, 8'd33, 8'd200, 8'd32, 8'd64, 8'd1, 8'd0,
                                 8'd4, 8'd4, 8'd4, 8'd33};
        logic [1:0]  vc [12] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd1, 2'd3, 2'd3, 2'd1,
                                 2'd2, 2'd1, 2'd1, 2'd3};
        logic        vf [12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                                 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] ed [12] = '{32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF,
                                 32'h0000_0000, 32'h0000_0001, 32'h8000_0001, 32'h1234_5678,
                                 32'hF800_0000, 32'h0000_0001, 32'h0000_000F, 32'h6000_0000};
        logic        ec [12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                                 1'b0, 1'b1, 1'b0, 1'b0};
        int          el [12] = '{2, 3, 1, 2, 2, 1, 2, 1, 2, 2, 2, 2};
        logic [31:0] od;
        logic        oc;
        int          lat;
        for (int i = 0; i < 12; i++) begin
            run_req(vd[i], va[i], vc[i], vf[i], od, oc, lat);
            checks++;
            if (od !== ed[i] || oc !== ec[i] || lat != el[i]) begin
                errors++;
                $display("FAIL vec%0d: data=%h carry=%b lat=%0d want data=%h carry=%b lat=%0d",
                         i, od, oc, lat, ed[i], ec[i], el[i]);
            end
            release_resp();
            checks++;
            if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d_release: ready=%b valid=%b want 1 0", i, req_ready, resp_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] od;
        logic        oc;
        int          lat;
        run_req(32'h0000_0001, 8'd4, 2'd0, 1'b0, od, oc, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== 32'h0000_0010 || resp_carry !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold%0d: valid=%b data=%h carry=%b ready=%b want 1 00000010 0 0",
                         i, resp_valid, resp_data, resp_carry, req_ready);
            end
        end
        release_resp();
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: ready=%b valid=%b want 1 0", req_ready, resp_valid);
        end
    endtask

    task automatic test_reset_mid_pass();
        logic [31:0] od;
        logic        oc;
        int          lat;
        req_valid  = 1'b1;
        req_data   = 32'h0000_0001;
        req_amount = 8'd32;
        req_code   = 2'd0;
        req_cflag  = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset_n   = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        checks++;
        if (resp_valid !== 1'b0 || resp_data !== 32'h0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset: valid=%b data=%h ready=%b want 0 0 1", resp_valid, resp_data, req_ready);
        end
        lat = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (resp_valid) lat++;
        end
        checks++;
        if (lat != 0) begin
            errors++;
            $display("FAIL stale_resp: valid_cycles=%0d want 0", lat);
        end
        run_req(32'h0000_0003, 8'd1, 2'd3, 1'b0, od, oc, lat);
        checks++;
        if (od !== 32'h8000_0001 || oc !== 1'b1 || lat != 2) begin
            errors++;
            $display("FAIL after_reset: data=%h carry=%b lat=%0d want 80000001 1 2", od, oc, lat);
        end
        release_resp();
    endtask

    initial begin
        req_valid  = 1'b0;
        req_data   = '0;
        req_amount = '0;
        req_code   = '0;
        req_cflag  = 1'b0;
        resp_ready = 1'b0;
        reset_n    = 1'b0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid_pass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Sequences the 32-bit barrel shifter (shifter32) for register-specified ARM shifts, where the shift amount is Rs[7:0] (0..255).
- The shifter accepts only a 5-bit amount, and its 0 encoding means "by 32" or RRX. This block therefore decomposes each request into 0, 1 or 2 shifter passes.
- Results and carry are registered behind a valid/ready handshake.
- Sits between the decode/register-read stage and the ALU operand-2 path.

Parameters:
- FULLW, 32, datapath width (shared constant)
- WIDTH, 5, shifter amount width (shared constant)
- SHIFTCODEW, 2, shift opcode width (shared constant)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept (high only in IDLE)
- req_data  in  32  value to shift (Rm)
- req_amount  in  8  shift amount, Rs[7:0]
- req_code  in  2  LSL=0, LSR=1, ASR=2, ROR=3
- req_cflag  in  1  current CPSR C flag
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_data  out  32  shifted result
- resp_carry  out  1  shifter carry-out

Behaviour:
- Reset (reset_n low at a clk edge) has priority over everything. It forces state IDLE, resp_valid=0, resp_data=0, resp_carry=0. Any in-flight request is dropped with no response.
- States: IDLE, PASS1, PASS2, RESP. req_ready = (state==IDLE).
- IDLE: on req_valid, register data, amount, code and cflag, then classify:
  - Trivial, go directly to RESP:
    - amount==0: data unchanged, carry=cflag.
    - LSL/LSR with amount>32: data 0, carry 0.
    - ROR with amount!=0 and amount[4:0]==0: data unchanged, carry=data[31].
  - ASR with amount>=32: one pass with shiftby=0 (result all sign bits, carry=data[31]) -> PASS1.
  - LSR with amount==32: one pass with shiftby=0 -> PASS1.
  - LSL with amount==32: two passes of LSL 16 (result 0, carry=data[0]) -> PASS1 then PASS2.
  - Any code with amount 1..31 (ROR uses amount[4:0]): one pass -> PASS1.
- PASS1: drive the shifter from the registered operands and capture out/carryout. Go to PASS2 if two passes are flagged, else to RESP.
- PASS2: feed the captured PASS1 result back through the shifter with LSL 16 and capture again -> RESP.
- RESP: resp_valid=1, resp_data/resp_carry held stable. On resp_ready, go to IDLE with resp_valid=0 on the next cycle. No same-cycle re-accept: req_ready stays low while in RESP.
- The shifter is never driven with shiftby=0 for ROR, so RRX is never issued. RRX is an immediate-shift form and is outside this block's scope.
- Latency, accept edge to resp_valid high:
  - trivial: 1 cycle
  - single pass: 2 cycles
  - LSL #32: 3 cycles
- Throughput: at most one request per 2 cycles (trivial case with resp_ready tied high).
- Operand registers change only on accept. resp_* change only on entering RESP or on reset.

Decomposition:
- Shared defines file (existing) holds:
  - FULLW, WIDTH, SHIFTCODEW
  - LSL/LSR/ASR/ROR codes
  - new state encodings SEQ_IDLE, SEQ_PASS1, SEQ_PASS2, SEQ_RESP
- One sub-module: a single shifter32 instance whose inputs are muxed by state.
- Classification logic stays inline; no further sub-modules.

Test Plan:
- LSL, data=0x0000_0001, amount=4, cflag=0 -> after 2 cycles resp_data=0x0000_0010, carry=0.
- LSL, data=0x8000_0001, amount=32 -> after 3 cycles resp_data=0, carry=1. Then amount=33 -> 1 cycle, data=0, carry=0.
- ASR, data=0x8000_0000, amount=200 -> resp_data=0xFFFF_FFFF, carry=1. LSR, data=0x8000_0000, amount=32 -> data=0, carry=1.
- ROR, data=0x0000_0001, amount=64 -> data=0x0000_0001, carry=0. ROR, data=0x0000_0003, amount=1 -> data=0x8000_0001, carry=1. Any code, amount=0, cflag=1 -> data unchanged, carry=1.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid and resp_data stable, req_ready=0 throughout. Release -> req_ready=1 next cycle.
- Reset mid-PASS1 (reset_n=0 for one edge) -> state IDLE, resp_valid=0, resp_data=0, no stale response. The next request completes normally.
